// File: rtl/aes_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_iter
//
// Iterative forward AES SubBytes. A 128-bit state is accepted over a
// valid/ready handshake. LANES bytes per clock are then replaced in place by
// their forward S-box value. After K = 16/LANES cycles the result is held
// until the consumer takes it.
//
// Ports
//   clk       rising-edge clock
//   rstN      asynchronous, active-low reset
//   inData    state to substitute; byte 0 = inData[127:120]
//   inValid   inData valid
//   inReady   engine can accept a block this cycle
//   outData   working register (meaningful only while outValid=1)
//   outValid  outData holds a complete result
//   outReady  consumer takes outData this cycle
// ---------------------------------------------------------------------------
module aes_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic [127:0] inData,
   input  logic         inValid,
   output logic         inReady,
   output logic [127:0] outData,
   output logic         outValid,
   input  logic         outReady
);

   localparam int K  = 16 / LANES;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [7:0]      work_reg  [16];
   logic [7:0]      work_next [16];
   logic [7:0]      lane_in   [LANES];
   logic [7:0]      lane_out  [LANES];
   logic            load;
   logic            step;
   logic            last;

   // Forward S-box. Each row is one FIPS-197 table row (high nibble). The
   // low nibble selects the byte within the row, leftmost byte first.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [127:0] row;
      logic [127:0] sh;
      case (x[7:4])
         4'h0:    row = 128'h637c777bf26b6fc53001672bfed7ab76;
         4'h1:    row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
         4'h2:    row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
         4'h3:    row = 128'h04c723c31896059a071280e2eb27b275;
         4'h4:    row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
         4'h5:    row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
         4'h6:    row = 128'hd0efaafb434d338545f9027f503c9fa8;
         4'h7:    row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
         4'h8:    row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
         4'h9:    row = 128'h60814fdc222a908846eeb814de5e0bdb;
         4'ha:    row = 128'he0323a0a4906245cc2d3ac629195e479;
         4'hb:    row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
         4'hc:    row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
         4'hd:    row = 128'h703eb5664803f60e613557b986c11d9e;
         4'he:    row = 128'he1f8981169d98e949b1e87e9ce5528df;
         default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      endcase
      sh = row << {x[3:0], 3'b000};
      return sh[127:120];
   endfunction

   assign last     = (cnt_reg == CW'(K - 1));
   assign outValid = (state_reg == DONE);
   // Depends only on state and outReady so a producer may wait on it.
   assign inReady  = (state_reg == IDLE) || ((state_reg == DONE) && outReady);

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (inValid) begin
               load       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (outReady) begin
               if (inValid) begin
                  load       = 1'b1;
                  state_next = BUSY;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The counter stops at K-1 and is cleared by the next accept.
   always_comb begin
      cnt_next = cnt_reg;
      if (load) begin
         cnt_next = '0;
      end else if (step && !last) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // Only LANES S-boxes: each lane reads byte (group*LANES + lane).
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_in[gi]  = work_reg[4'(int'(cnt_reg) * LANES + gi)];
         assign lane_out[gi] = sbox(lane_in[gi]);
      end
   endgenerate

   // Byte gi belongs to group gi/LANES. It is served by lane gi%LANES.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_byte
         localparam int G = gi / LANES;
         localparam int L = gi % LANES;
         logic hit;
         assign hit           = (state_reg == BUSY) && (cnt_reg == CW'(G));
         assign work_next[gi] = load ? inData[127 - 8*gi -: 8]
                              : (hit ? lane_out[L] : work_reg[gi]);
         assign outData[127 - 8*gi -: 8] = work_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         for (int i = 0; i < 16; i++) begin
            work_reg[i] <= 8'h00;
         end
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         work_reg  <= work_next;
      end
   end

endmodule
